// File: rtl/sram_fifo_ctrl.sv
// Streaming FIFO controller around a 1W1R SRAM macro with a 2-word prefetch buffer.
// Optional high-water mark tracking is enabled by defining SRAM_FIFO_HWM_EN.
module sram_fifo_ctrl #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_WMASKS = 4,
    parameter int DEPTH      = 34,
    parameter int LVL_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [LVL_WIDTH-1:0]  level,
    output logic                  sram_csb0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
`ifdef SRAM_FIFO_HWM_EN
    ,
    output logic [LVL_WIDTH-1:0]  hwm,
    input  logic                  hwm_clr
`endif
);

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [LVL_WIDTH-1:0]  sram_cnt_q, sram_cnt_d;
    logic                  rd_inflight_q, rd_inflight_d;
    logic [1:0]            pb_cnt_q, pb_cnt_d;
    logic [DATA_WIDTH-1:0] pbuf_q [2];
    logic [DATA_WIDTH-1:0] pbuf_d [2];

    logic       push;
    logic       pop;
    logic       rd;
    logic [2:0] occ;
    logic       pb_idx;

    assign s_ready     = rst_n & (sram_cnt_q != LVL_WIDTH'(DEPTH));
    assign push        = s_valid & s_ready;
    assign m_valid     = (pb_cnt_q != 2'd0);
    assign pop         = m_valid & m_ready;
    assign m_data      = pbuf_q[0];
    assign level       = sram_cnt_q + LVL_WIDTH'(rd_inflight_q) + LVL_WIDTH'(pb_cnt_q);

    assign sram_csb0   = ~push;
    assign sram_wmask0 = '1;
    assign sram_addr0  = wptr_q;
    assign sram_din0   = s_data;
    assign sram_csb1   = ~rd;
    assign sram_addr1  = rptr_q;

    // Issue a read only when the buffer slot it will land in is guaranteed free.
    always_comb begin
        occ = {1'b0, pb_cnt_q} + {2'b0, rd_inflight_q} - {2'b0, pop};
        rd  = rst_n & (sram_cnt_q != '0) & (occ < 3'd2);
    end

    // Pointer and SRAM occupancy bookkeeping; pointers wrap at DEPTH-1.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            if (wptr_q == ADDR_WIDTH'(DEPTH - 1)) wptr_d = '0;
            else wptr_d = wptr_q + ADDR_WIDTH'(1);
        end
        if (rd) begin
            if (rptr_q == ADDR_WIDTH'(DEPTH - 1)) rptr_d = '0;
            else rptr_d = rptr_q + ADDR_WIDTH'(1);
        end
        sram_cnt_d    = sram_cnt_q + LVL_WIDTH'(push) - LVL_WIDTH'(rd);
        rd_inflight_d = rd;
    end

    // Ordered prefetch buffer: pop shifts the head, returning data lands behind survivors.
    always_comb begin
        pbuf_d[0] = pbuf_q[0];
        pbuf_d[1] = pbuf_q[1];
        pb_idx    = ((pb_cnt_q - {1'b0, pop}) == 2'd1);
        if (pop) pbuf_d[0] = pbuf_q[1];
        if (rd_inflight_q) pbuf_d[pb_idx] = sram_dout1;
        pb_cnt_d = pb_cnt_q - {1'b0, pop} + {1'b0, rd_inflight_q};
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            sram_cnt_q    <= '0;
            rd_inflight_q <= 1'b0;
            pb_cnt_q      <= 2'd0;
            pbuf_q[0]     <= '0;
            pbuf_q[1]     <= '0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            sram_cnt_q    <= sram_cnt_d;
            rd_inflight_q <= rd_inflight_d;
            pb_cnt_q      <= pb_cnt_d;
            pbuf_q[0]     <= pbuf_d[0];
            pbuf_q[1]     <= pbuf_d[1];
        end
    end

`ifdef SRAM_FIFO_HWM_EN
    logic [LVL_WIDTH-1:0] hwm_q, hwm_d;

    assign hwm = hwm_q;

    // Track the peak level; a clear reloads the present level.
    always_comb begin
        hwm_d = hwm_q;
        if (hwm_clr) hwm_d = level;
        else if (level > hwm_q) hwm_d = level;
    end

    // High-water mark register.
    always_ff @(posedge clk) begin
        if (!rst_n) hwm_q <= '0;
        else hwm_q <= hwm_d;
    end
`endif

endmodule
